// File: rtl/golay_pkg.sv
// Shared definitions for the extended Golay (24,12) decoder.
// Holds the fixed B matrix, the decoder state encoding, a 12-bit popcount
// and the x·B product over GF(2). Bit [11] of a 12-bit word is column 0.
package golay_pkg;

  localparam int GW = 12;

  // Row i of B; B is symmetric and self-inverse (B·B = I).
  localparam logic [GW-1:0] B_ROW [GW] = '{
    12'hDC5, 12'hB8B, 12'h717, 12'hE2D, 12'hC5B, 12'h8B7,
    12'h16F, 12'h2DD, 12'h5B9, 12'hB71, 12'h6E3, 12'hFFE
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYND,
    S_CHK1,
    S_SCAN1,
    S_SYND2,
    S_CHK2,
    S_SCAN2,
    S_DONE
  } state_e;

  function automatic logic [3:0] popcount12(input logic [GW-1:0] x);
    logic [3:0] cnt;
    cnt = '0;
    for (int k = 0; k < GW; k++) begin
      cnt = cnt + {3'd0, x[k]};
    end
    return cnt;
  endfunction

  // x·B: XOR of B_ROW[i] for every set column i (column i is bit 11-i).
  function automatic logic [GW-1:0] mat_vec(input logic [GW-1:0] x);
    logic [GW-1:0] acc;
    acc = '0;
    for (int i = 0; i < GW; i++) begin
      if (x[GW-1-i]) acc = acc ^ B_ROW[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/golay_wt_le.sv
// Combinational Hamming-weight threshold test on a 12-bit word.
// Ports: vec_i (word under test), le2_o (weight <= 2), le3_o (weight <= 3).
// Zero latency; no flow control.
module golay_wt_le
  import golay_pkg::*;
(
  input  logic [GW-1:0] vec_i,
  output logic          le2_o,
  output logic          le3_o
);

  logic [3:0] wt;

  assign wt    = popcount12(vec_i);
  assign le2_o = (wt <= 4'd2);
  assign le3_o = (wt <= 4'd3);

endmodule

// File: rtl/golay2412_decoder.sv
// Extended Golay (24,12) decoder using the sequential syndrome / row-scan method.
// Ports: clk_clk, reset_reset_n (async low), start + codeword_in request;
// busy, done pulse, data_out, err_count, uncorrectable results.
// Latency 2..28 cycles from the start edge; start is ignored while busy.
module golay2412_decoder
  import golay_pkg::*;
(
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          start,
  input  logic [23:0]   codeword_in,
  output logic          busy,
  output logic          done,
  output logic [GW-1:0] data_out,
  output logic [1:0]    err_count,
  output logic          uncorrectable
);

  state_e        state_q, state_d;
  logic [23:0]   cw_q, cw_d;
  logic [GW-1:0] syn_q, syn_d;    // holds s, then s2 = s·B after SYND2
  logic [3:0]    idx_q, idx_d;
  logic [GW-1:0] data_q, data_d;
  logic [1:0]    errc_q, errc_d;
  logic          unc_q, unc_d;

  logic [GW-1:0] wt_vec;
  logic          wt_le2, wt_le3;

  // One weight checker serves every test state: the syndrome itself in the
  // CHK states, the syndrome with the current B row removed in the SCAN states.
  always_comb begin
    wt_vec = syn_q;
    if (state_q == S_SCAN1 || state_q == S_SCAN2) begin
      wt_vec = syn_q ^ B_ROW[idx_q];
    end
  end

  golay_wt_le u_wt (
    .vec_i (wt_vec),
    .le2_o (wt_le2),
    .le3_o (wt_le3)
  );

  always_comb begin
    logic          hit;
    logic [GW-1:0] e1, e2, u_row;
    logic [3:0]    wsum;

    state_d = state_q;
    cw_d    = cw_q;
    syn_d   = syn_q;
    idx_d   = idx_q;
    data_d  = data_q;
    errc_d  = errc_q;
    unc_d   = unc_q;
    hit     = 1'b0;
    e1      = '0;
    e2      = '0;
    u_row   = 12'h800 >> idx_q;
    wsum    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cw_d    = codeword_in;
          state_d = S_SYND;
        end
      end
      S_SYND: begin
        syn_d   = mat_vec(cw_q[23:12]) ^ cw_q[11:0];
        state_d = S_CHK1;
      end
      S_CHK1: begin
        if (wt_le3) begin
          hit = 1'b1;
          e2  = syn_q;
        end else begin
          idx_d   = '0;
          state_d = S_SCAN1;
        end
      end
      S_SCAN1: begin
        if (wt_le2) begin
          hit = 1'b1;
          e1  = u_row;
          e2  = wt_vec;
        end else if (idx_q == 4'd11) begin
          state_d = S_SYND2;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_SYND2: begin
        syn_d   = mat_vec(syn_q);
        state_d = S_CHK2;
      end
      S_CHK2: begin
        if (wt_le3) begin
          hit = 1'b1;
          e1  = syn_q;
        end else begin
          idx_d   = '0;
          state_d = S_SCAN2;
        end
      end
      S_SCAN2: begin
        if (wt_le2) begin
          hit = 1'b1;
          e1  = wt_vec;
          e2  = u_row;
        end else if (idx_q == 4'd11) begin
          // No pattern of weight <= 3 exists: report the message untouched.
          data_d  = cw_q[23:12];
          errc_d  = '0;
          unc_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (hit) begin
      wsum    = popcount12(e1) + popcount12(e2);
      data_d  = cw_q[23:12] ^ e1;
      errc_d  = wsum[1:0];
      unc_d   = 1'b0;
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      cw_q    <= '0;
      syn_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      errc_q  <= '0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      syn_q   <= syn_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      errc_q  <= errc_d;
      unc_q   <= unc_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign data_out      = data_q;
  assign err_count     = errc_q;
  assign uncorrectable = unc_q;

endmodule

// File: tb/tb_golay2412_decoder.sv
`timescale 1ns/1ps
module tb_golay2412_decoder;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        start;
  logic [23:0] codeword_in;
  logic        busy;
  logic        done;
  logic [11:0] data_out;
  logic [1:0]  err_count;
  logic        uncorrectable;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] rows [12] = '{
    12'hDC5, 12'hB8B, 12'h717, 12'hE2D, 12'hC5B, 12'h8B7,
    12'h16F, 12'h2DD, 12'h5B9, 12'hB71, 12'h6E3, 12'hFFE
  };
  logic [23:0] cw_tab [4096];

  // Directed vectors: codeword, data_out, err_count, uncorrectable, latency, mid-decode start
  logic [23:0] pl_cw  [5] = '{24'h000000, 24'h800DC2, 24'h000DC5, 24'hE00000, 24'h00000F};
  logic [11:0] pl_d   [5] = '{12'h000, 12'h800, 12'h800, 12'h000, 12'h000};
  logic [1:0]  pl_ec  [5] = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd0};
  logic        pl_u   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int          pl_lat [5] = '{2, 2, 3, 16, 28};
  int          pl_pls [5] = '{-1, -1, -1, -1, 6};

  always #5 clk_clk = ~clk_clk;

  golay2412_decoder dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .start         (start),
    .codeword_in   (codeword_in),
    .busy          (busy),
    .done          (done),
    .data_out      (data_out),
    .err_count     (err_count),
    .uncorrectable (uncorrectable)
  );

  // Every valid codeword is {m, m·B}; the decoder's answer is the unique
  // codeword within distance 3 of the received word, if any.
  task automatic build_table();
    logic [11:0] p;
    for (int m = 0; m < 4096; m++) begin
      p = '0;
      for (int i = 0; i < 12; i++) begin
        if (((m >> (11 - i)) & 1) == 1) p = p ^ rows[i];
      end
      cw_tab[m] = {12'(m), p};
    end
  endtask

  // Latency follows from which correction path the error shape selects.
  task automatic ref_decode(input logic [23:0] r, output logic [11:0] d,
                            output logic [1:0] ec, output logic u, output int lat);
    logic [23:0] e;
    logic [11:0] e1, e2;
    int w1, w2;
    d = r[23:12]; ec = 2'd0; u = 1'b1; lat = 28;
    for (int m = 0; m < 4096; m++) begin
      e = r ^ cw_tab[m];
      if ($countones(e) <= 3) begin
        e1 = e[23:12]; e2 = e[11:0];
        w1 = $countones(e1); w2 = $countones(e2);
        d = r[23:12] ^ e1; ec = 2'(w1 + w2); u = 1'b0;
        if (w1 == 0) lat = 2;
        else if (w1 == 1) begin
          for (int k = 0; k < 12; k++) if (e1[11-k]) lat = 3 + k;
        end else if (w2 == 0) lat = 16;
        else begin
          for (int k = 0; k < 12; k++) if (e2[11-k]) lat = 17 + k;
        end
      end
    end
  endtask

  // Issues one start, scrambles codeword_in during the decode, optionally
  // pulses start at cycle pulse_at, and reports what the DUT produced.
  task automatic run_decode(input logic [23:0] cw, input int pulse_at, output int lat,
                            output logic [11:0] d, output logic [1:0] ec,
                            output logic u, output int busy_bad);
    busy_bad = 0; lat = -1; d = '0; ec = '0; u = 1'b0;
    @(negedge clk_clk); start = 1'b1; codeword_in = cw;
    @(negedge clk_clk); start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      codeword_in = 24'($urandom);
      if (!busy) busy_bad++;
      if (done) begin
        lat = n; d = data_out; ec = err_count; u = uncorrectable;
        break;
      end
      start = (n == pulse_at);
      @(negedge clk_clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0; start = 1'b0; codeword_in = '0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b exp 0", done); end
    n_vec++; if (data_out !== 12'h000) begin n_err++; $display("FAIL reset_data got %0h exp 0", data_out); end
    n_vec++; if (err_count !== 2'd0) begin n_err++; $display("FAIL reset_errc got %0d exp 0", err_count); end
    n_vec++; if (uncorrectable !== 1'b0) begin n_err++; $display("FAIL reset_unc got %0b exp 0", uncorrectable); end
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  task automatic test_directed();
    int lat, bb; logic [11:0] d; logic [1:0] ec; logic u;
    for (int t = 0; t < 5; t++) begin
      run_decode(pl_cw[t], pl_pls[t], lat, d, ec, u, bb);
      n_vec++; if (lat !== pl_lat[t]) begin n_err++; $display("FAIL dir%0d_latency got %0d exp %0d", t, lat, pl_lat[t]); end
      n_vec++; if (d !== pl_d[t]) begin n_err++; $display("FAIL dir%0d_data got %0h exp %0h", t, d, pl_d[t]); end
      n_vec++; if (ec !== pl_ec[t]) begin n_err++; $display("FAIL dir%0d_errc got %0d exp %0d", t, ec, pl_ec[t]); end
      n_vec++; if (u !== pl_u[t]) begin n_err++; $display("FAIL dir%0d_unc got %0b exp %0b", t, u, pl_u[t]); end
      n_vec++; if (bb !== 0) begin n_err++; $display("FAIL dir%0d_busy_gaps got %0d exp 0", t, bb); end
      @(negedge clk_clk);
      n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL dir%0d_idle got busy/done %0b exp 00", t, {busy, done}); end
    end
  endtask

  task automatic test_random();
    int lat, bb, elat, w; logic [11:0] d, ed; logic [1:0] ec, eec; logic u, eu;
    logic [23:0] mask, r;
    for (int t = 0; t < 50; t++) begin
      if (t < 40) begin
        w = $urandom_range(0, 4); mask = '0;
        while ($countones(mask) < w) mask = mask | (24'd1 << $urandom_range(0, 23));
        r = cw_tab[$urandom_range(0, 4095)] ^ mask;
      end else begin
        r = 24'($urandom);
      end
      ref_decode(r, ed, eec, eu, elat);
      run_decode(r, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1, lat, d, ec, u, bb);
      n_vec++; if (lat !== elat) begin n_err++; $display("FAIL rnd_latency cw %06h got %0d exp %0d", r, lat, elat); end
      n_vec++; if (d !== ed) begin n_err++; $display("FAIL rnd_data cw %06h got %0h exp %0h", r, d, ed); end
      n_vec++; if (ec !== eec) begin n_err++; $display("FAIL rnd_errc cw %06h got %0d exp %0d", r, ec, eec); end
      n_vec++; if (u !== eu) begin n_err++; $display("FAIL rnd_unc cw %06h got %0b exp %0b", r, u, eu); end
      n_vec++; if (bb !== 0) begin n_err++; $display("FAIL rnd_busy_gaps cw %06h got %0d exp 0", r, bb); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bb, elat; logic [11:0] d, ed; logic [1:0] ec, eec; logic u, eu;
    logic [23:0] rb;
    run_decode(24'h800DC5 ^ 24'h000300, -1, lat, d, ec, u, bb);
    n_vec++; if (d !== 12'h800 || ec !== 2'd2) begin n_err++; $display("FAIL b2b_first got %0h/%0d exp 800/2", d, ec); end
    // Start raised during the DONE cycle must be dropped; held into IDLE it is taken.
    rb = cw_tab[12'h5A3] ^ 24'h040001;
    ref_decode(rb, ed, eec, eu, elat);
    start = 1'b1; codeword_in = rb;
    @(negedge clk_clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_start_in_done got busy %0b exp 0", busy); end
    @(negedge clk_clk); start = 1'b0; codeword_in = '0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (done) begin lat = n; d = data_out; ec = err_count; u = uncorrectable; break; end
      @(negedge clk_clk);
    end
    n_vec++; if (lat !== elat) begin n_err++; $display("FAIL b2b_latency got %0d exp %0d", lat, elat); end
    n_vec++; if (d !== ed || ec !== eec || u !== eu) begin n_err++; $display("FAIL b2b_result got %0h/%0d/%0b exp %0h/%0d/%0b", d, ec, u, ed, eec, eu); end
    @(negedge clk_clk);
  endtask

  task automatic test_midreset();
    int lat, bb, elat, dones; logic [11:0] d, ed; logic [1:0] ec, eec; logic u, eu;
    run_decode(24'h000DC5, -1, lat, d, ec, u, bb);
    n_vec++; if (data_out !== 12'h800 || err_count !== 2'd1) begin n_err++; $display("FAIL mrst_pre got %0h/%0d exp 800/1", data_out, err_count); end
    @(negedge clk_clk); start = 1'b1; codeword_in = 24'h00000F;
    @(negedge clk_clk); start = 1'b0;
    repeat (9) @(negedge clk_clk);
    reset_reset_n = 1'b0;
    #1;
    n_vec++; if ({busy, done, data_out, err_count, uncorrectable} !== 17'd0) begin
      n_err++; $display("FAIL mrst_outputs got busy %0b done %0b data %0h errc %0d unc %0b exp all 0",
                        busy, done, data_out, err_count, uncorrectable);
    end
    dones = 0;
    repeat (3) begin @(negedge clk_clk); if (done) dones++; end
    reset_reset_n = 1'b1;
    repeat (20) begin @(negedge clk_clk); if (done) dones++; end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL mrst_no_done got %0d pulses exp 0", dones); end
    ref_decode(24'h900DC5, ed, eec, eu, elat);
    run_decode(24'h900DC5, -1, lat, d, ec, u, bb);
    n_vec++; if (lat !== elat || lat !== 6) begin n_err++; $display("FAIL mrst_after_latency got %0d exp 6", lat); end
    n_vec++; if (d !== 12'h800 || ec !== 2'd1 || u !== 1'b0) begin n_err++; $display("FAIL mrst_after_result got %0h/%0d/%0b exp 800/1/0", d, ec, u); end
  endtask

  initial begin
    build_table();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
